// File: rtl/fifo_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rst_seq
// Description : Write-domain reset/flush sequencer for an async FIFO, with a
//               handshake against the read domain's reset status.
// Revision    : 1.0
// ============================================================================
module fifo_rst_seq #(
    parameter int HOLD_CYC = 8,
    parameter int TO_CYC   = 1023,
    parameter int CNT_W    = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic atpg_mode,
    input  logic flush_req,
    input  logic rd_rst_stat,
    input  logic err_clr,
    output logic fifo_rst_n,
    output logic wr_gate,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        S_ASSERT    = 3'd0,
        S_WAIT_ASRT = 3'd1,
        S_HOLD      = 3'd2,
        S_RELEASE   = 3'd3,
        S_WAIT_REL  = 3'd4,
        S_DONE      = 3'd5,
        S_IDLE      = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(TO_CYC - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_rd_meta;
    logic             r_rd_s;
    logic             r_fifo_rst_n;
    logic             r_wr_gate;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             w_fifo_rst_n_nxt;
    logic             w_wr_gate_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_ASSERT;
            r_cnt        <= '0;
            r_rd_meta    <= 1'b0;
            r_rd_s       <= 1'b0;
            r_fifo_rst_n <= 1'b0;
            r_wr_gate    <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rd_meta    <= rd_rst_stat;
            r_rd_s       <= r_rd_meta;
            r_fifo_rst_n <= w_fifo_rst_n_nxt;
            r_wr_gate    <= w_wr_gate_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_ASSERT: begin
                w_state_nxt = S_WAIT_ASRT;
                w_cnt_nxt   = '0;
            end
            S_WAIT_ASRT: begin
                if (r_rd_s) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TO_LAST) begin
                    w_state_nxt = S_ERR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            // Hold is purely timed; rd_s is not consulted here
            S_HOLD: begin
                if (r_cnt == C_HOLD_LAST) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_WAIT_REL;
                w_cnt_nxt   = '0;
            end
            S_WAIT_REL: begin
                if (!r_rd_s) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == C_TO_LAST) begin
                    w_state_nxt = S_ERR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (flush_req) begin
                    w_state_nxt = S_ASSERT;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    w_state_nxt = S_ASSERT;
                end
            end
            default: begin
                w_state_nxt = S_ASSERT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they carry no input paths
    always_comb begin
        w_fifo_rst_n_nxt = (w_state_nxt == S_RELEASE) || (w_state_nxt == S_WAIT_REL) ||
                           (w_state_nxt == S_DONE)    || (w_state_nxt == S_IDLE);
        w_wr_gate_nxt    = (w_state_nxt != S_IDLE);
        w_busy_nxt       = (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
        w_done_nxt       = (w_state_nxt == S_DONE);
        w_err_nxt        = (w_state_nxt == S_ERR);
    end

    assign fifo_rst_n = atpg_mode ? ~rst : r_fifo_rst_n;
    assign wr_gate    = r_wr_gate;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rst_seq
// Description : Scoreboard bench for fifo_rst_seq; expectations are queued
//               by cycle and checked on the falling edge.
// Revision    : 1.0
// ============================================================================
module tb_fifo_rst_seq;

    logic clk = 1'b0;
    logic rst;
    logic atpg_mode;
    logic flush_req;
    logic rd_rst_stat;
    logic err_clr;
    logic fifo_rst_n;
    logic wr_gate;
    logic busy;
    logic done;
    logic err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_seen = 0;

    // Output vector order: {fifo_rst_n, wr_gate, busy, done, err}
    localparam logic [4:0] C_RST  = 5'b01100;
    localparam logic [4:0] C_REL  = 5'b11100;
    localparam logic [4:0] C_DONE = 5'b11110;
    localparam logic [4:0] C_IDLE = 5'b10000;
    localparam logic [4:0] C_ERR  = 5'b01001;
    localparam logic [4:0] C_ALL  = 5'b11111;

    typedef struct {
        string      name;
        int         cyc;
        logic [4:0] exp;
        logic [4:0] mask;
    } exp_t;

    exp_t sb[$];

    fifo_rst_seq #(.HOLD_CYC(8), .TO_CYC(1023), .CNT_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .atpg_mode  (atpg_mode),
        .flush_req  (flush_req),
        .rd_rst_stat(rd_rst_stat),
        .err_clr    (err_clr),
        .fifo_rst_n (fifo_rst_n),
        .wr_gate    (wr_gate),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

    task automatic push(input string n, input int c, input logic [4:0] e, input logic [4:0] m);
        exp_t x;
        x.name = n;
        x.cyc  = c;
        x.exp  = e;
        x.mask = m;
        sb.push_back(x);
    endtask

    // A level driven just after edge k reaches the FSM decision at edge k+3
    task automatic test_reset();
        int   c0 = cyc;
        int   d0 = done_seen;
        int   k;
        exp_t e;
        logic [4:0] got;
        push("por_first", c0 + 1,  C_RST,  C_ALL);
        push("por_held",  c0 + 3,  C_RST,  C_ALL);
        push("por_wait",  c0 + 4,  C_RST,  C_ALL);
        push("por_hold",  c0 + 13, C_RST,  C_ALL);
        push("por_rel",   c0 + 14, C_REL,  C_ALL);
        push("por_wrel",  c0 + 25, C_REL,  C_ALL);
        push("por_done",  c0 + 26, C_DONE, C_ALL);
        push("por_idle",  c0 + 27, C_IDLE, C_ALL);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            k = cyc - c0;
            if (k == 3)  begin rst = 1'b0; rd_rst_stat = 1'b1; end
            if (k == 23) rd_rst_stat = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = {fifo_rst_n, wr_gate, busy, done, err};
                total++;
                if (e.cyc != cyc || (got & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", e.name, cyc, got, e.exp, e.mask);
                end
            end
        end
        total++;
        if (done_seen - d0 !== 1) begin
            bad++;
            $display("FAIL por_done_count got=%0d want=1", done_seen - d0);
        end
    endtask

    task automatic test_flush();
        int   c0 = cyc;
        int   d0 = done_seen;
        int   k;
        exp_t e;
        logic [4:0] got;
        push("fl_idle",  c0 + 1,  C_IDLE, C_ALL);
        push("fl_asrt",  c0 + 2,  C_RST,  C_ALL);
        push("fl_hold",  c0 + 14, C_RST,  C_ALL);
        push("fl_rel",   c0 + 15, C_REL,  C_ALL);
        push("fl_wrel",  c0 + 22, C_REL,  C_ALL);
        push("fl_done",  c0 + 23, C_DONE, C_ALL);
        push("fl_idle2", c0 + 24, C_IDLE, C_ALL);
        for (int i = 1; i <= 26; i++) begin
            @(posedge clk); #1;
            k = cyc - c0;
            flush_req = (k == 1);
            if (k == 4)  rd_rst_stat = 1'b1;
            if (k == 20) rd_rst_stat = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = {fifo_rst_n, wr_gate, busy, done, err};
                total++;
                if (e.cyc != cyc || (got & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", e.name, cyc, got, e.exp, e.mask);
                end
            end
        end
        total++;
        if (done_seen - d0 !== 1) begin
            bad++;
            $display("FAIL fl_done_count got=%0d want=1", done_seen - d0);
        end
    endtask

    task automatic test_ignored_req();
        int   c0 = cyc;
        int   d0 = done_seen;
        int   k;
        exp_t e;
        logic [4:0] got;
        push("ig_asrt",   c0 + 2,  C_RST,  C_ALL);
        push("ig_hold_a", c0 + 11, C_RST,  C_ALL);
        push("ig_hold_b", c0 + 12, C_RST,  C_ALL);
        push("ig_rel",    c0 + 15, C_REL,  C_ALL);
        push("ig_done",   c0 + 23, C_DONE, C_ALL);
        push("ig_idle",   c0 + 24, C_IDLE, C_ALL);
        push("ig_clr",    c0 + 26, C_IDLE, C_ALL);
        push("ig_stay",   c0 + 32, C_IDLE, C_ALL);
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk); #1;
            k = cyc - c0;
            flush_req = (k == 1) || (k == 10);
            err_clr   = (k == 25);
            if (k == 4)  rd_rst_stat = 1'b1;
            if (k == 20) rd_rst_stat = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = {fifo_rst_n, wr_gate, busy, done, err};
                total++;
                if (e.cyc != cyc || (got & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", e.name, cyc, got, e.exp, e.mask);
                end
            end
        end
        total++;
        if (done_seen - d0 !== 1) begin
            bad++;
            $display("FAIL ig_done_count got=%0d want=1", done_seen - d0);
        end
    endtask

    task automatic test_timeout();
        int   c0 = cyc;
        int   d0 = done_seen;
        int   k;
        exp_t e;
        logic [4:0] got;
        push("to_asrt",   c0 + 2,    C_RST,  C_ALL);
        push("to_last",   c0 + 1025, C_RST,  C_ALL);
        push("to_err",    c0 + 1026, C_ERR,  C_ALL);
        push("to_sticky", c0 + 1029, C_ERR,  C_ALL);
        push("to_clr",    c0 + 1031, C_RST,  C_ALL);
        push("to_hold",   c0 + 1040, C_RST,  C_ALL);
        push("to_rel",    c0 + 1041, C_REL,  C_ALL);
        push("to_done",   c0 + 1048, C_DONE, C_ALL);
        push("to_idle",   c0 + 1049, C_IDLE, C_ALL);
        for (int i = 1; i <= 1052; i++) begin
            @(posedge clk); #1;
            k = cyc - c0;
            flush_req = (k == 1) || (k == 1027);
            err_clr   = (k == 1030);
            if (k == 1030) rd_rst_stat = 1'b1;
            if (k == 1045) rd_rst_stat = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = {fifo_rst_n, wr_gate, busy, done, err};
                total++;
                if (e.cyc != cyc || (got & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", e.name, cyc, got, e.exp, e.mask);
                end
            end
        end
        total++;
        if (done_seen - d0 !== 1) begin
            bad++;
            $display("FAIL to_done_count got=%0d want=1", done_seen - d0);
        end
    endtask

    task automatic test_reset_midop();
        int   c0 = cyc;
        int   d0 = done_seen;
        int   k;
        exp_t e;
        logic [4:0] got;
        push("rm_asrt",  c0 + 2,  C_RST,  C_ALL);
        push("rm_hold4", c0 + 10, C_RST,  C_ALL);
        push("rm_rst",   c0 + 11, C_RST,  C_ALL);
        push("rm_hold",  c0 + 21, C_RST,  C_ALL);
        push("rm_rel",   c0 + 22, C_REL,  C_ALL);
        push("rm_done",  c0 + 28, C_DONE, C_ALL);
        push("rm_idle",  c0 + 29, C_IDLE, C_ALL);
        for (int i = 1; i <= 31; i++) begin
            @(posedge clk); #1;
            k = cyc - c0;
            flush_req = (k == 1);
            rst       = (k == 10);
            if (k == 4)  rd_rst_stat = 1'b1;
            if (k == 25) rd_rst_stat = 1'b0;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = {fifo_rst_n, wr_gate, busy, done, err};
                total++;
                if (e.cyc != cyc || (got & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", e.name, cyc, got, e.exp, e.mask);
                end
            end
        end
        total++;
        if (done_seen - d0 !== 1) begin
            bad++;
            $display("FAIL rm_done_count got=%0d want=1", done_seen - d0);
        end
    endtask

    task automatic test_atpg();
        int   c0 = cyc;
        int   k;
        exp_t e;
        logic [4:0] got;
        for (int j = 1; j <= 11; j++) begin
            push("atpg_mux", c0 + j, (j % 3 == 1) ? 5'b00000 : 5'b10000, 5'b10000);
        end
        push("atpg_off", c0 + 12, C_RST, C_ALL);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            k = cyc - c0;
            atpg_mode = (k <= 11);
            rst       = (k <= 11) && (k % 3 == 1);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                got = {fifo_rst_n, wr_gate, busy, done, err};
                total++;
                if (e.cyc != cyc || (got & e.mask) !== (e.exp & e.mask)) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", e.name, cyc, got, e.exp, e.mask);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
    endtask

    initial begin
        rst         = 1'b1;
        atpg_mode   = 1'b0;
        flush_req   = 1'b0;
        rd_rst_stat = 1'b0;
        err_clr     = 1'b0;
        test_reset();
        test_flush();
        test_ignored_req();
        test_timeout();
        test_reset_midop();
        test_atpg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
